alu_sequenced_interface: RTL and testbench

Parametrised, fully registered ALU front-end for the board: takes raw switches and two raw push-buttons, synchronises and debounces them, and steps through a field-select FSM to load operand 1, operand 2 and opcode. It contains its own registered ALU with status flags and drives the result to the LEDs. It replaces the previous unregistered operand-interface + combinational-ALU pairing at board top level.

---
 rtl/alu_sequenced_interface.sv | 250 +++++++++++++++++++++++++
 tb/tb_alu_sequenced_interface.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequenced_interface.sv
// -----------------------------------------------------------------------------
// alu_sequenced_interface
//
// Board-level ALU front-end. Two raw push-buttons are synchronised, debounced
// and edge-detected; a four-state field selector steps OP1 -> OP2 -> OPCODE ->
// SHOW, and the "set" button copies the switches into the selected field. A
// registered ALU evaluates the field registers every cycle and drives the LEDs
// and status flags.
//
// Parameters
//   NB_OP           opcode width (NB_OP <= NB_DATA)
//   NB_DATA         operand / result width (>= 4)
//   DEBOUNCE_CYCLES consecutive differing samples before a button level is
//                   accepted (>= 2)
//
// Ports
//   clk          in   system clock, rising edge
//   i_reset      in   asynchronous reset, active low
//   i_switches   in   raw switch value, sampled only on a load
//   i_btn_select in   raw button, advances the selected field
//   i_btn_set    in   raw button, loads the switches into the selected field
//   o_leds       out  registered ALU result
//   o_sel        out  current field: 0 OP1, 1 OP2, 2 OPCODE, 3 SHOW
//   o_valid      out  all three fields loaded at least once since reset
//   o_zero       out  result == 0
//   o_carry      out  ADD carry-out / SUB borrow
//   o_overflow   out  signed overflow of ADD / SUB
//   o_err        out  unsupported opcode
// -----------------------------------------------------------------------------
module alu_sequenced_interface_btn #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic pulse
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             synced;
    logic             stable;
    logic             stable_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            synced    <= 1'b0;
            stable    <= 1'b0;
            stable_q  <= 1'b0;
            cnt       <= '0;
        end else begin
            sync_meta <= btn_raw;
            synced    <= sync_meta;
            stable_q  <= stable;
            // Any sample that agrees with the accepted level restarts the count,
            // so only an uninterrupted run of differing samples flips the level.
            if (synced == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= synced;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Rising edge of the debounced level only; releases produce nothing.
    assign pulse = stable & ~stable_q;
endmodule

module alu_sequenced_interface #(
    parameter int NB_OP           = 6,
    parameter int NB_DATA         = 8,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_switches,
    input  logic               i_btn_select,
    input  logic               i_btn_set,
    output logic [NB_DATA-1:0] o_leds,
    output logic [1:0]         o_sel,
    output logic               o_valid,
    output logic               o_zero,
    output logic               o_carry,
    output logic               o_overflow,
    output logic               o_err
);
    localparam logic [NB_OP-1:0]   OP_ADD    = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0]   OP_SUB    = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0]   OP_AND    = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0]   OP_OR     = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0]   OP_XOR    = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0]   OP_NOR    = NB_OP'(6'b100111);
    localparam logic [NB_OP-1:0]   OP_SRA    = NB_OP'(6'b000011);
    localparam logic [NB_OP-1:0]   OP_SRL    = NB_OP'(6'b000010);
    localparam logic [NB_DATA-1:0] SHIFT_LIM = NB_DATA'(NB_DATA);

    typedef enum logic [1:0] {
        SEL_OP1    = 2'd0,
        SEL_OP2    = 2'd1,
        SEL_OPCODE = 2'd2,
        SEL_SHOW   = 2'd3
    } sel_t;

    typedef struct packed {
        logic [NB_DATA-1:0] result;
        logic               zero;
        logic               carry;
        logic               overflow;
        logic               err;
    } alu_out_t;

    function automatic alu_out_t alu_eval(
        input logic signed [NB_DATA-1:0] a,
        input logic signed [NB_DATA-1:0] b,
        input logic        [NB_OP-1:0]   op
    );
        alu_out_t         r;
        logic [NB_DATA:0] wide;
        r    = '0;
        wide = '0;
        case (op)
            OP_ADD: begin
                wide       = {1'b0, a} + {1'b0, b};
                r.result   = wide[NB_DATA-1:0];
                r.carry    = wide[NB_DATA];
                // Same-signed operands producing a differently-signed sum.
                r.overflow = (a[NB_DATA-1] == b[NB_DATA-1]) &&
                             (r.result[NB_DATA-1] != a[NB_DATA-1]);
            end
            OP_SUB: begin
                r.result   = a - b;
                r.carry    = $unsigned(a) < $unsigned(b);
                r.overflow = (a[NB_DATA-1] != b[NB_DATA-1]) &&
                             (r.result[NB_DATA-1] != a[NB_DATA-1]);
            end
            OP_AND: r.result = a & b;
            OP_OR:  r.result = a | b;
            OP_XOR: r.result = a ^ b;
            OP_NOR: r.result = ~(a | b);
            OP_SRA: begin
                if ($unsigned(b) >= SHIFT_LIM) r.result = {NB_DATA{a[NB_DATA-1]}};
                else                           r.result = a >>> $unsigned(b);
            end
            OP_SRL: begin
                if ($unsigned(b) >= SHIFT_LIM) r.result = '0;
                else                           r.result = $unsigned(a) >> $unsigned(b);
            end
            default: r.err = 1'b1;
        endcase
        r.zero = (r.result == '0);
        return r;
    endfunction

    logic                      select_pulse;
    logic                      set_pulse;
    sel_t                      state;
    sel_t                      state_next;
    logic signed [NB_DATA-1:0] operand1_p0;
    logic signed [NB_DATA-1:0] operand2_p0;
    logic        [NB_OP-1:0]   opcode_p0;
    logic                      loaded1;
    logic                      loaded2;
    logic                      loaded3;
    alu_out_t                  alu_p0;
    alu_out_t                  alu_p1;

    alu_sequenced_interface_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_select (
        .clk     (clk),
        .rst_n   (i_reset),
        .btn_raw (i_btn_select),
        .pulse   (select_pulse)
    );

    alu_sequenced_interface_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_set (
        .clk     (clk),
        .rst_n   (i_reset),
        .btn_raw (i_btn_set),
        .pulse   (set_pulse)
    );

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) state <= SEL_OP1;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (select_pulse) begin
            case (state)
                SEL_OP1:    state_next = SEL_OP2;
                SEL_OP2:    state_next = SEL_OPCODE;
                SEL_OPCODE: state_next = SEL_SHOW;
                default:    state_next = SEL_OP1;
            endcase
        end
    end

    always_comb begin
        o_sel = state;
    end

    // ---- stage p0: field registers (load uses the pre-advance field) ----
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            operand1_p0 <= '0;
            operand2_p0 <= '0;
            opcode_p0   <= '0;
            loaded1     <= 1'b0;
            loaded2     <= 1'b0;
            loaded3     <= 1'b0;
        end else if (set_pulse) begin
            case (state)
                SEL_OP1: begin
                    operand1_p0 <= i_switches;
                    loaded1     <= 1'b1;
                end
                SEL_OP2: begin
                    operand2_p0 <= i_switches;
                    loaded2     <= 1'b1;
                end
                SEL_OPCODE: begin
                    opcode_p0 <= i_switches[NB_OP-1:0];
                    loaded3   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_valid = loaded1 & loaded2 & loaded3;
    assign alu_p0  = alu_eval(operand1_p0, operand2_p0, opcode_p0);

    // ---- stage p1: registered result and flags ----
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) alu_p1 <= '0;
        else          alu_p1 <= alu_p0;
    end

    assign o_leds     = alu_p1.result;
    assign o_zero     = alu_p1.zero;
    assign o_carry    = alu_p1.carry;
    assign o_overflow = alu_p1.overflow;
    assign o_err      = alu_p1.err;
endmodule

// File: tb/tb_alu_sequenced_interface.sv
module tb_alu_sequenced_interface;
    localparam int NB_OP   = 6;
    localparam int NB_DATA = 8;
    localparam int DEB     = 4;

    logic             clk = 1'b0;
    logic             i_reset;
    logic [7:0]       i_switches;
    logic             i_btn_select;
    logic             i_btn_set;
    logic [7:0]       o_leds;
    logic [1:0]       o_sel;
    logic             o_valid, o_zero, o_carry, o_overflow, o_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the user-visible state.
    int m_op1, m_op2, m_opc, m_sel;
    bit m_l1, m_l2, m_l3;

    alu_sequenced_interface #(.NB_OP(NB_OP), .NB_DATA(NB_DATA), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_switches   (i_switches),
        .i_btn_select (i_btn_select),
        .i_btn_set    (i_btn_set),
        .o_leds       (o_leds),
        .o_sel        (o_sel),
        .o_valid      (o_valid),
        .o_zero       (o_zero),
        .o_carry      (o_carry),
        .o_overflow   (o_overflow),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {result[7:0], zero, carry, overflow, err}.
    function automatic logic [11:0] ref_alu(input int op1, input int op2, input int opc);
        int sa, sb, full, s, res;
        bit c, v, e;
        sa = (op1 > 127) ? op1 - 256 : op1;
        sb = (op2 > 127) ? op2 - 256 : op2;
        c = 0; v = 0; e = 0; res = 0;
        case (opc)
            32: begin
                full = op1 + op2; res = full % 256; c = (full > 255);
                s = sa + sb; v = (s > 127) || (s < -128);
            end
            34: begin
                res = (op1 - op2 + 256) % 256; c = (op1 < op2);
                s = sa - sb; v = (s > 127) || (s < -128);
            end
            36: res = op1 & op2;
            37: res = op1 | op2;
            38: res = op1 ^ op2;
            39: res = 255 - (op1 | op2);
            3:  res = (op2 >= 8) ? ((sa < 0) ? 255 : 0) : ((sa >>> op2) & 255);
            2:  res = (op2 >= 8) ? 0 : (op1 >> op2);
            default: e = 1;
        endcase
        return {res[7:0], (res == 0), c, v, e};
    endfunction

    task automatic check_all(input string tag);
        logic [11:0] exp;
        exp = ref_alu(m_op1, m_op2, m_opc);
        check({tag, "_leds"}, o_leds, exp[11:4]);
        check({tag, "_zero"}, o_zero, exp[3]);
        check({tag, "_carry"}, o_carry, exp[2]);
        check({tag, "_ovf"}, o_overflow, exp[1]);
        check({tag, "_err"}, o_err, exp[0]);
        check({tag, "_sel"}, o_sel, m_sel);
        check({tag, "_valid"}, o_valid, m_l1 & m_l2 & m_l3);
    endtask

    // Holds the chosen raw buttons for `hold` cycles, releases, then lets the
    // debouncers and result register settle. A press registers iff hold >= DEB.
    task automatic press(input bit sel_b, input bit set_b, input int sw, input int hold);
        i_switches   = sw[7:0];
        i_btn_select = sel_b;
        i_btn_set    = set_b;
        repeat (hold) tick();
        i_btn_select = 1'b0;
        i_btn_set    = 1'b0;
        repeat (10) tick();
        if (hold >= DEB) begin
            if (set_b) begin
                case (m_sel)
                    0: begin m_op1 = sw % 256; m_l1 = 1; end
                    1: begin m_op2 = sw % 256; m_l2 = 1; end
                    2: begin m_opc = sw % 64;  m_l3 = 1; end
                    default: ;
                endcase
            end
            if (sel_b) m_sel = (m_sel + 1) % 4;
        end
    endtask

    task automatic goto_field(input int target);
        for (int k = 0; k < 4 && m_sel != target; k++) press(1'b1, 1'b0, 0, DEB + 1);
    endtask

    task automatic set_fields(input int a, input int b, input int c);
        goto_field(0); press(1'b0, 1'b1, a, DEB + 1);
        goto_field(1); press(1'b0, 1'b1, b, DEB + 1);
        goto_field(2); press(1'b0, 1'b1, c, DEB + 1);
    endtask

    task automatic model_reset();
        m_op1 = 0; m_op2 = 0; m_opc = 0; m_sel = 0;
        m_l1 = 0; m_l2 = 0; m_l3 = 0;
    endtask

    initial begin
        int ops[8];
        int sw, act, hold;
        ops = '{32, 34, 36, 37, 38, 39, 3, 2};
        model_reset();
        i_reset = 1'b0; i_switches = 8'h00; i_btn_select = 1'b0; i_btn_set = 1'b0;
        repeat (3) tick();
        check("rst_sel", o_sel, 2'd0);
        check("rst_leds", o_leds, 8'h00);
        check("rst_valid", o_valid, 1'b0);
        check("rst_err", o_err, 1'b0);
        i_reset = 1'b1;
        check("rel_err_before_clk", o_err, 1'b0);
        tick();
        check("rel_err_after_clk", o_err, 1'b1);
        check_all("post_reset");

        // ADD overflow
        set_fields(8'h7F, 8'h01, 6'b100000);
        check("add_leds_const", o_leds, 8'h80);
        check("add_ovf_const", o_overflow, 1'b1);
        check("add_valid_const", o_valid, 1'b1);
        check_all("add");
        // SUB borrow
        set_fields(8'h00, 8'h01, 6'b100010);
        check("sub_leds_const", o_leds, 8'hFF);
        check("sub_carry_const", o_carry, 1'b1);
        check_all("sub");
        // shifts
        set_fields(8'h80, 3, 6'b000011);
        check("sra3_const", o_leds, 8'hF0);
        goto_field(1); press(1'b0, 1'b1, 9, DEB + 1);
        check("sra9_const", o_leds, 8'hFF);
        goto_field(2); press(1'b0, 1'b1, 6'b000010, DEB + 1);
        check("srl9_const", o_leds, 8'h00);
        check("srl9_zero_const", o_zero, 1'b1);
        check_all("srl9");

        // Glitch shorter than the debounce window, then an exactly timed press.
        set_fields(8'h10, 8'h05, 6'b100000);
        press(1'b0, 1'b1, 8'h25, DEB - 1);
        check_all("glitch");
        i_switches = 8'h22;
        i_btn_set  = 1'b1;
        repeat (7) tick();
        check("held_edge7_old", o_leds, 8'h15);
        tick();
        check("held_edge8_new", o_leds, 8'h0B);
        i_switches = 8'h24;
        repeat (92) tick();
        i_btn_set = 1'b0;
        repeat (10) tick();
        m_opc = 34; m_l3 = 1;
        check("held_once_leds", o_leds, 8'h0B);
        check_all("held_once");

        // Set and select together in OP2, wrap from SHOW, set ignored in SHOW.
        goto_field(1);
        press(1'b1, 1'b1, 8'h03, DEB + 1);
        check("both_sel_const", o_sel, 2'd2);
        check_all("both");
        goto_field(3);
        press(1'b0, 1'b1, 8'hAA, DEB + 1);
        check_all("show_set");
        press(1'b1, 1'b0, 0, DEB + 1);
        check("wrap_sel_const", o_sel, 2'd0);

        // Random actions against the model.
        for (int n = 0; n < 60; n++) begin
            act  = $urandom_range(1, 3);
            hold = $urandom_range(DEB - 2, DEB + 4);
            if (m_sel == 2 && $urandom_range(0, 3) != 0)
                sw = ($urandom_range(0, 3) << 6) | ops[$urandom_range(0, 7)];
            else
                sw = $urandom_range(0, 255);
            press(act[1], act[0], sw, hold);
            check_all("rand");
        end

        // Reset while select is held mid-debounce.
        set_fields(8'h40, 8'h40, 6'b100000);
        check("pre_rst_leds", o_leds, 8'h80);
        i_btn_select = 1'b1;
        repeat (4) tick();
        i_reset = 1'b0;
        #1;
        check("arst_leds", o_leds, 8'h00);
        check("arst_ovf", o_overflow, 1'b0);
        check("arst_sel", o_sel, 2'd0);
        check("arst_valid", o_valid, 1'b0);
        repeat (2) tick();
        i_reset = 1'b1;
        model_reset();
        repeat (6) tick();
        check("redeb_edge6_sel", o_sel, 2'd0);
        check("redeb_err", o_err, 1'b1);
        tick();
        check("redeb_edge7_sel", o_sel, 2'd1);
        i_btn_select = 1'b0;
        m_sel = 1;
        repeat (10) tick();
        check_all("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
